lcd_pattern_gen: RTL and testbench

// - Pixel-colour stage directly downstream of the LTM LCD sync generator.
// - Takes the raw counters (Columna/Fila) and strobes (DEN/HD/VD) and produces 8-bit RGB
//   for the 800x480 active window.
// - Generates one of four test patterns, including a bouncing square animated once per frame.
// - Re-times HD/VD/DEN so that sync and colour reach the panel on the same cycle.

---
 rtl/lcd_pattern_gen.sv | 177 +++++++++++++++++
 tb/tb_lcd_pattern_gen.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/lcd_pattern_gen.sv
// Pixel-colour stage for the 800x480 LTM panel: turns sync-generator counters into RGB
// test patterns (bars, checker, grid, bouncing square) with sync re-timed to match.
module lcd_pattern_gen #(
    parameter int H_OFFSET = 216,
    parameter int V_OFFSET = 35,
    parameter int H_ACTIVE = 800,
    parameter int V_ACTIVE = 480,
    parameter int BOX_SIZE = 64
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [1:0]  iMODE,
    input  logic        iPAUSE,
    input  logic [10:0] Columna,
    input  logic [9:0]  Fila,
    input  logic        DEN,
    input  logic        HD,
    input  logic        VD,
    output logic [7:0]  oR,
    output logic [7:0]  oG,
    output logic [7:0]  oB,
    output logic        oHD,
    output logic        oVD,
    output logic        oDEN,
    output logic [7:0]  oFRAME
);

    typedef enum logic [1:0] {
        MODE_BARS    = 2'd0,
        MODE_CHECKER = 2'd1,
        MODE_GRID    = 2'd2,
        MODE_SQUARE  = 2'd3
    } mode_e;

    localparam logic [9:0] BX_MAX  = 10'(H_ACTIVE - BOX_SIZE);
    localparam logic [8:0] BY_MAX  = 9'(V_ACTIVE - BOX_SIZE);
    localparam logic [9:0] BAR_W   = 10'(H_ACTIVE / 8);
    localparam logic [9:0] X_LAST  = 10'(H_ACTIVE - 1);
    localparam logic [8:0] Y_LAST  = 9'(V_ACTIVE - 1);
    localparam logic [10:0] BOX_W  = 11'(BOX_SIZE);

    // Stage 1 registers
    logic [9:0] x_q;
    logic [8:0] y_q;
    logic       act_q, hd_q, vd_q, den_q;

    // Per-frame state
    logic       vd_d;
    mode_e      mode_q;
    logic [9:0] bx, bx_next;
    logic [8:0] by, by_next;
    logic       dx_neg, dx_next, dy_neg, dy_next;
    logic       fe;
    logic [23:0] rgb;

    assign fe = vd_d & ~VD;

    // NOTE: all clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            x_q   <= '0;
            y_q   <= '0;
            act_q <= 1'b0;
            hd_q  <= 1'b1;
            vd_q  <= 1'b1;
            den_q <= 1'b1;
        end else begin
            x_q   <= 10'(Columna - 11'(H_OFFSET));
            y_q   <= 9'(Fila - 10'(V_OFFSET));
            act_q <= ~DEN;
            hd_q  <= HD;
            vd_q  <= VD;
            den_q <= DEN;
        end
    end

    // Bounce: reverse at either edge, stepping one pixel back inside the range.
    always_comb begin
        bx_next = bx;
        by_next = by;
        dx_next = dx_neg;
        dy_next = dy_neg;
        if (fe && !iPAUSE) begin
            if (!dx_neg && bx == BX_MAX) begin
                dx_next = 1'b1;
                bx_next = bx - 10'd1;
            end else if (dx_neg && bx == '0) begin
                dx_next = 1'b0;
                bx_next = 10'd1;
            end else begin
                bx_next = dx_neg ? bx - 10'd1 : bx + 10'd1;
            end
            if (!dy_neg && by == BY_MAX) begin
                dy_next = 1'b1;
                by_next = by - 9'd1;
            end else if (dy_neg && by == '0) begin
                dy_next = 1'b0;
                by_next = 9'd1;
            end else begin
                by_next = dy_neg ? by - 9'd1 : by + 9'd1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            vd_d   <= 1'b1;
            mode_q <= MODE_BARS;
            oFRAME <= '0;
            bx     <= '0;
            by     <= '0;
            dx_neg <= 1'b0;
            dy_neg <= 1'b0;
        end else begin
            vd_d   <= VD;
            bx     <= bx_next;
            by     <= by_next;
            dx_neg <= dx_next;
            dy_neg <= dy_next;
            if (fe) begin
                oFRAME <= oFRAME + 8'd1;
                mode_q <= mode_e'(iMODE);
            end
        end
    end

    logic [9:0]  bar_idx;
    logic [10:0] x_ext, bx_ext;
    logic [9:0]  y_ext, by_ext;
    logic        in_box;

    assign bar_idx = x_q / BAR_W;
    assign x_ext   = {1'b0, x_q};
    assign bx_ext  = {1'b0, bx};
    assign y_ext   = {1'b0, y_q};
    assign by_ext  = {1'b0, by};
    assign in_box  = (x_ext >= bx_ext) && (x_ext < bx_ext + BOX_W) &&
                     (y_ext >= by_ext) && (y_ext < by_ext + 10'(BOX_SIZE));

    always_comb begin
        rgb = 24'h000000;
        unique case (mode_q)
            MODE_BARS: begin
                case (bar_idx)
                    10'd0:   rgb = 24'hFFFFFF;
                    10'd1:   rgb = 24'hFFFF00;
                    10'd2:   rgb = 24'h00FFFF;
                    10'd3:   rgb = 24'h00FF00;
                    10'd4:   rgb = 24'hFF00FF;
                    10'd5:   rgb = 24'hFF0000;
                    10'd6:   rgb = 24'h0000FF;
                    default: rgb = 24'h000000;
                endcase
            end
            MODE_CHECKER: rgb = (x_q[5] ^ y_q[5]) ? 24'hFFFFFF : 24'h000000;
            MODE_GRID: rgb = (x_q[4:0] == 5'd0 || y_q[4:0] == 5'd0 ||
                              x_q == X_LAST || y_q == Y_LAST) ? 24'hFFFFFF : 24'h000080;
            MODE_SQUARE: rgb = in_box ? 24'hFF0000 : 24'h202020;
            default: rgb = 24'h000000;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            {oR, oG, oB} <= 24'h000000;
            oHD          <= 1'b1;
            oVD          <= 1'b1;
            oDEN         <= 1'b1;
        end else begin
            {oR, oG, oB} <= act_q ? rgb : 24'h000000;
            oHD          <= hd_q;
            oVD          <= vd_q;
            oDEN         <= den_q;
        end
    end

endmodule

// File: tb/tb_lcd_pattern_gen.sv
// Directed self-checking bench for lcd_pattern_gen: reset, patterns, latency, bounce,
// mode latching, pause, long VD low and mid-line reset.
module tb_lcd_pattern_gen;

    logic        CLK = 1'b0;
    logic        RST;
    logic [1:0]  iMODE;
    logic        iPAUSE;
    logic [10:0] Columna;
    logic [9:0]  Fila;
    logic        DEN, HD, VD;
    logic [7:0]  oR, oG, oB;
    logic        oHD, oVD, oDEN;
    logic [7:0]  oFRAME;

    int n_checks = 0;
    int n_errors = 0;

    lcd_pattern_gen dut (
        .CLK     (CLK),
        .RST     (RST),
        .iMODE   (iMODE),
        .iPAUSE  (iPAUSE),
        .Columna (Columna),
        .Fila    (Fila),
        .DEN     (DEN),
        .HD      (HD),
        .VD      (VD),
        .oR      (oR),
        .oG      (oG),
        .oB      (oB),
        .oHD     (oHD),
        .oVD     (oVD),
        .oDEN    (oDEN),
        .oFRAME  (oFRAME)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive one pixel, hold it for the 2-cycle latency, compare RGB.
    task automatic pixel(input string tag, input int col, input int row, input logic den,
                         input logic [23:0] exp);
        @(negedge CLK);
        Columna = 11'(col);
        Fila    = 10'(row);
        DEN     = den;
        repeat (2) @(negedge CLK);
        check(tag, {8'h0, oR, oG, oB}, {8'h0, exp});
        DEN = 1'b1;
    endtask

    // One frame event: VD low for a single cycle.
    task automatic frame_pulse(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            VD = 1'b0;
            @(negedge CLK);
            VD = 1'b1;
        end
    endtask

    initial begin
        RST = 1'b1; iMODE = 2'd0; iPAUSE = 1'b0;
        Columna = 11'd300; Fila = 10'd200; DEN = 1'b0; HD = 1'b0; VD = 1'b0;

        // Reset with arbitrary active inputs
        repeat (3) @(negedge CLK);
        check("rst_rgb", {8'h0, oR, oG, oB}, 32'h0);
        check("rst_hd", {31'h0, oHD}, 32'h1);
        check("rst_vd", {31'h0, oVD}, 32'h1);
        check("rst_den", {31'h0, oDEN}, 32'h1);
        check("rst_frame", {24'h0, oFRAME}, 32'h0);
        HD = 1'b1; VD = 1'b1; DEN = 1'b1;
        @(negedge CLK);
        RST = 1'b0;

        // Colour bars
        pixel("bar0_left", 216, 100, 1'b0, 24'hFFFFFF);
        pixel("bar0_right", 315, 100, 1'b0, 24'hFFFFFF);
        pixel("bar1_left", 316, 100, 1'b0, 24'hFFFF00);
        pixel("bar7_last", 1015, 100, 1'b0, 24'h000000);
        pixel("bar5", 716, 100, 1'b0, 24'hFF0000);
        pixel("bar_den_off", 216, 100, 1'b1, 24'h000000);

        // Sync latency (VD pulse is also frame 1)
        @(negedge CLK); HD = 1'b0;
        @(negedge CLK); check("hd_lat1", {31'h0, oHD}, 32'h1); HD = 1'b1;
        @(negedge CLK); check("hd_lat2", {31'h0, oHD}, 32'h0);
        @(negedge CLK); check("hd_lat3", {31'h0, oHD}, 32'h1);
        @(negedge CLK); VD = 1'b0;
        @(negedge CLK); check("vd_lat1", {31'h0, oVD}, 32'h1); VD = 1'b1;
        @(negedge CLK); check("vd_lat2", {31'h0, oVD}, 32'h0);
        @(negedge CLK); check("vd_lat3", {31'h0, oVD}, 32'h1);
        @(negedge CLK); DEN = 1'b0;
        @(negedge CLK); check("den_lat1", {31'h0, oDEN}, 32'h1); DEN = 1'b1;
        @(negedge CLK); check("den_lat2", {31'h0, oDEN}, 32'h0);
        @(negedge CLK); check("den_lat3", {31'h0, oDEN}, 32'h1);
        check("frame_1", {24'h0, oFRAME}, 32'd1);

        // Mode change mid-frame is ignored until the next VD falling edge
        iMODE = 2'd1;
        pixel("latch_bars_persist", 216, 100, 1'b0, 24'hFFFFFF);
        frame_pulse(1);
        pixel("checker_00", 216, 100, 1'b0, 24'h000000);
        pixel("checker_10", 248, 100, 1'b0, 24'hFFFFFF);
        pixel("checker_11", 248, 132, 1'b0, 24'h000000);
        check("frame_2", {24'h0, oFRAME}, 32'd2);

        // Grid
        iMODE = 2'd2;
        frame_pulse(1);
        pixel("grid_x0", 216, 100, 1'b0, 24'hFFFFFF);
        pixel("grid_fill", 217, 36, 1'b0, 24'h000080);
        pixel("grid_xlast", 1015, 36, 1'b0, 24'hFFFFFF);
        pixel("grid_ylast", 217, 514, 1'b0, 24'hFFFFFF);
        pixel("grid_fill2", 249, 68, 1'b0, 24'h000080);
        pixel("grid_x32", 248, 68, 1'b0, 24'hFFFFFF);

        // Square after 4 moves: box at (4,4)
        iMODE = 2'd3;
        frame_pulse(1);
        iPAUSE = 1'b1;
        frame_pulse(5);
        iPAUSE = 1'b0;
        check("frame_9", {24'h0, oFRAME}, 32'd9);
        pixel("pause_tl_in", 220, 39, 1'b0, 24'hFF0000);
        pixel("pause_left_out", 219, 39, 1'b0, 24'h202020);
        pixel("pause_br_in", 283, 102, 1'b0, 24'hFF0000);
        pixel("pause_right_out", 284, 102, 1'b0, 24'h202020);

        // 732 more moves: 736 total -> bx=736, by=96
        frame_pulse(732);
        check("frame_741", {24'h0, oFRAME}, 32'd229);
        pixel("b736_left_in", 952, 131, 1'b0, 24'hFF0000);
        pixel("b736_left_out", 951, 131, 1'b0, 24'h202020);
        pixel("b736_br_in", 1015, 194, 1'b0, 24'hFF0000);
        pixel("b736_below", 1015, 195, 1'b0, 24'h202020);
        pixel("b736_above", 952, 130, 1'b0, 24'h202020);

        // Move 737: bx=735 after reversal
        frame_pulse(1);
        pixel("b737_x799_out", 1015, 135, 1'b0, 24'h202020);
        pixel("b737_x735_in", 951, 135, 1'b0, 24'hFF0000);
        pixel("b737_x798_in", 1014, 135, 1'b0, 24'hFF0000);

        // Move 738: still heading left, bx=734
        frame_pulse(1);
        pixel("b738_x798_out", 1014, 135, 1'b0, 24'h202020);
        pixel("b738_x734_in", 950, 135, 1'b0, 24'hFF0000);

        // Long VD low: a single frame event
        @(negedge CLK); VD = 1'b0;
        repeat (1056) @(negedge CLK);
        VD = 1'b1;
        repeat (3) @(negedge CLK);
        check("vd_long_frame", {24'h0, oFRAME}, 32'd232);
        pixel("vd_long_x733_in", 949, 135, 1'b0, 24'hFF0000);
        pixel("vd_long_x797_out", 1013, 135, 1'b0, 24'h202020);

        // Reset mid-line with a visible pixel streaming in
        @(negedge CLK);
        Columna = 11'd216; Fila = 10'd100; DEN = 1'b0;
        repeat (2) @(negedge CLK);
        check("pre_rst_square", {8'h0, oR, oG, oB}, 32'h00202020);
        RST = 1'b1;
        @(negedge CLK);
        check("mid_rst_rgb", {8'h0, oR, oG, oB}, 32'h0);
        check("mid_rst_frame", {24'h0, oFRAME}, 32'h0);
        check("mid_rst_den", {31'h0, oDEN}, 32'h1);
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        check("post_rst_bars", {8'h0, oR, oG, oB}, 32'h00FFFFFF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
